vend_ctrl_multi: RTL and testbench

Parametrised multi-item vending controller, successor to the single-item vending FSM.
- Accumulates coin credit, checks price and stock per item, and dispenses the item.
- Returns change one coin per handshake using greedy denomination selection.
- Sits between the coin acceptor front-end and the dispenser/change-hopper drivers.

---
 rtl/vend_pkg.sv | 32 +++
 rtl/vend_change_dispenser.sv | 88 ++++++++
 rtl/vend_ctrl_multi.sv | 225 ++++++++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller.
// Contents: coin code encodings, fail code encodings, the controller state
// enum and the coin_value() helper that maps a coin code to its value.
package vend_pkg;

    localparam logic [1:0] COIN_5  = 2'b00;
    localparam logic [1:0] COIN_10 = 2'b01;
    localparam logic [1:0] COIN_20 = 2'b10;
    localparam logic [1:0] COIN_50 = 2'b11;

    localparam logic [1:0] FC_NONE   = 2'b00;
    localparam logic [1:0] FC_CREDIT = 2'b01;
    localparam logic [1:0] FC_STOCK  = 2'b10;
    localparam logic [1:0] FC_INDEX  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CREDIT = 2'b01,
        ST_VEND   = 2'b10,
        ST_CHANGE = 2'b11
    } state_e;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 8'd5;
            COIN_10: return 8'd10;
            COIN_20: return 8'd20;
            default: return 8'd50;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Change payout engine: pays an amount out one coin at a time using greedy
// denomination selection over a valid/ready handshake with the hopper.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, amount       load a new payout amount (pulse)
//   coin_out_valid/code offered change coin (registered, code stable while stalled)
//   coin_out_ready      hopper accepts the offered coin
//   done                payout finished this cycle (residual < 5 forfeited)
//   rem_next            amount still owed after this cycle (next register value)
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int BAL_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BAL_W-1:0] amount,
    input  logic             coin_out_ready,
    output logic             coin_out_valid,
    output logic [1:0]       coin_out_code,
    output logic             done,
    output logic [BAL_W-1:0] rem_next
);

    localparam logic [BAL_W-1:0] FIVE = BAL_W'(5);

    logic             active_q, active_d;
    logic             valid_q, valid_d;
    logic [1:0]       code_q, code_d;
    logic [BAL_W-1:0] rem_q, rem_d, rem_after;

    function automatic logic [1:0] pick(input logic [BAL_W-1:0] a);
        if (a >= BAL_W'(50)) return COIN_50;
        if (a >= BAL_W'(20)) return COIN_20;
        if (a >= BAL_W'(10)) return COIN_10;
        return COIN_5;
    endfunction

    always_comb begin
        active_d  = active_q;
        valid_d   = valid_q;
        code_d    = code_q;
        rem_d     = rem_q;
        done      = 1'b0;
        rem_after = rem_q;
        if (valid_q && coin_out_ready)
            rem_after = rem_q - BAL_W'(coin_value(code_q));
        if (start) begin
            active_d = 1'b1;
            rem_d    = amount;
            valid_d  = (amount >= FIVE);
            code_d   = pick(amount);
        end else if (active_q) begin
            if (rem_after < FIVE) begin
                // Anything below the smallest coin cannot be paid and is forfeited.
                active_d = 1'b0;
                valid_d  = 1'b0;
                code_d   = COIN_5;
                rem_d    = '0;
                done     = 1'b1;
            end else begin
                valid_d = 1'b1;
                code_d  = pick(rem_after);
                rem_d   = rem_after;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            code_q   <= COIN_5;
            rem_q    <= '0;
        end else begin
            active_q <= active_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            rem_q    <= rem_d;
        end
    end

    assign coin_out_valid = valid_q;
    assign coin_out_code  = code_q;
    assign rem_next       = rem_d;

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: accumulates coin credit, checks stock and
// price per item, dispenses, and returns change via vend_change_dispenser.
// Ports: coin input (coin_valid/coin_code/coin_reject), purchase request
// (vend_req/vend_sel -> vend_valid/vend_item or vend_fail/fail_code), cancel,
// price table item_prices, restock/restock_sel, change hopper handshake
// (coin_out_valid/coin_out_code/coin_out_ready), balance and busy status.
// Optional macro VEND_AUDIT_EN adds sales_count (16b) and revenue (24b).
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int  NUM_ITEMS  = 4,
    parameter int  BAL_W      = 8,
    parameter int  MAX_BAL    = 200,
    parameter int  STOCK_W    = 4,
    parameter int  INIT_STOCK = 8,
    localparam int SEL_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coin_valid,
    input  logic [1:0]                 coin_code,
    output logic                       coin_reject,
    input  logic                       vend_req,
    input  logic [SEL_W-1:0]           vend_sel,
    input  logic                       cancel,
    input  logic [NUM_ITEMS*BAL_W-1:0] item_prices,
    input  logic                       restock,
    input  logic [SEL_W-1:0]           restock_sel,
    output logic                       vend_valid,
    output logic [SEL_W-1:0]           vend_item,
    output logic                       vend_fail,
    output logic [1:0]                 fail_code,
    output logic                       coin_out_valid,
    output logic [1:0]                 coin_out_code,
    input  logic                       coin_out_ready,
    output logic [BAL_W-1:0]           balance,
    output logic                       busy
`ifdef VEND_AUDIT_EN
    ,
    output logic [15:0]                sales_count,
    output logic [23:0]                revenue
`endif
);

    state_e             state_q, state_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_d [NUM_ITEMS];
    logic               coin_reject_q, coin_reject_d;
    logic               vend_valid_q, vend_valid_d;
    logic [SEL_W-1:0]   vend_item_q, vend_item_d;
    logic               vend_fail_q, vend_fail_d;
    logic [1:0]         fail_code_q, fail_code_d;
    logic               busy_q, busy_d;

    logic [BAL_W-1:0]   sel_price;
    logic [STOCK_W-1:0] sel_stock;
    logic               sel_ok;
    logic [BAL_W:0]     coin_sum;
    logic               coin_fits;
    logic               chg_start, chg_done;
    logic [BAL_W-1:0]   chg_rem_next;

    // Change payout starts on the transition into CHANGE, with the balance as it stands.
    assign chg_start = (state_q == ST_CREDIT && cancel) ||
                       (state_q == ST_VEND && balance_q != '0);

    vend_change_dispenser #(.BAL_W(BAL_W)) u_change (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (chg_start),
        .amount         (balance_q),
        .coin_out_ready (coin_out_ready),
        .coin_out_valid (coin_out_valid),
        .coin_out_code  (coin_out_code),
        .done           (chg_done),
        .rem_next       (chg_rem_next)
    );

    always_comb begin
        sel_price = '0;
        sel_stock = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (vend_sel == SEL_W'(i)) begin
                sel_price = item_prices[i*BAL_W +: BAL_W];
                sel_stock = stock_q[i];
            end
        end
        sel_ok    = ({1'b0, vend_sel} < (SEL_W+1)'(NUM_ITEMS));
        coin_sum  = {1'b0, balance_q} + (BAL_W+1)'(coin_value(coin_code));
        coin_fits = (coin_sum <= (BAL_W+1)'(MAX_BAL));
    end

    always_comb begin
        state_d       = state_q;
        balance_d     = balance_q;
        stock_d       = stock_q;
        coin_reject_d = 1'b0;
        vend_valid_d  = 1'b0;
        vend_fail_d   = 1'b0;
        vend_item_d   = vend_item_q;
        fail_code_d   = fail_code_q;
        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                // Priority cancel > coin > vend_req; losers are dropped.
                // Cancel only acts once credit exists, so in IDLE it falls through.
                if (cancel && state_q == ST_CREDIT) begin
                    state_d = ST_CHANGE;
                end else if (coin_valid) begin
                    if (coin_fits) begin
                        balance_d = coin_sum[BAL_W-1:0];
                        state_d   = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (vend_req) begin
                    if (!sel_ok) begin
                        vend_fail_d = 1'b1;
                        fail_code_d = FC_INDEX;
                    end else if (sel_stock == '0) begin
                        vend_fail_d = 1'b1;
                        fail_code_d = FC_STOCK;
                    end else if (balance_q < sel_price) begin
                        vend_fail_d = 1'b1;
                        fail_code_d = FC_CREDIT;
                    end else begin
                        state_d      = ST_VEND;
                        balance_d    = balance_q - sel_price;
                        vend_valid_d = 1'b1;
                        vend_item_d  = vend_sel;
                        for (int i = 0; i < NUM_ITEMS; i++)
                            if (vend_sel == SEL_W'(i) && stock_q[i] != '0)
                                stock_d[i] = stock_q[i] - 1'b1;
                    end
                end
                if (state_q == ST_IDLE && restock) begin
                    for (int i = 0; i < NUM_ITEMS; i++)
                        if (restock_sel == SEL_W'(i))
                            stock_d[i] = STOCK_W'(INIT_STOCK);
                end
            end
            ST_VEND: begin
                state_d = (balance_q != '0) ? ST_CHANGE : ST_IDLE;
            end
            default: begin
                balance_d = chg_rem_next;
                if (chg_done) state_d = ST_IDLE;
            end
        endcase
        if (coin_valid && (state_q == ST_VEND || state_q == ST_CHANGE))
            coin_reject_d = 1'b1;
        busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            balance_q     <= '0;
            for (int i = 0; i < NUM_ITEMS; i++)
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            coin_reject_q <= 1'b0;
            vend_valid_q  <= 1'b0;
            vend_item_q   <= '0;
            vend_fail_q   <= 1'b0;
            fail_code_q   <= FC_NONE;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            balance_q     <= balance_d;
            stock_q       <= stock_d;
            coin_reject_q <= coin_reject_d;
            vend_valid_q  <= vend_valid_d;
            vend_item_q   <= vend_item_d;
            vend_fail_q   <= vend_fail_d;
            fail_code_q   <= fail_code_d;
            busy_q        <= busy_d;
        end
    end

    assign coin_reject = coin_reject_q;
    assign vend_valid  = vend_valid_q;
    assign vend_item   = vend_item_q;
    assign vend_fail   = vend_fail_q;
    assign fail_code   = fail_code_q;
    assign balance     = balance_q;
    assign busy        = busy_q;

`ifdef VEND_AUDIT_EN
    logic [15:0]      sales_q, sales_d;
    logic [23:0]      rev_q, rev_d;
    logic [BAL_W-1:0] price_q, price_d;
    logic [24:0]      rev_sum;

    // The sale is booked during the VEND cycle using the price captured on entry.
    always_comb begin
        price_d = price_q;
        sales_d = sales_q;
        rev_d   = rev_q;
        rev_sum = {1'b0, rev_q} + 25'(price_q);
        if (vend_valid_d) price_d = sel_price;
        if (state_q == ST_VEND) begin
            sales_d = (sales_q == 16'hFFFF) ? sales_q : sales_q + 16'd1;
            rev_d   = rev_sum[24] ? '1 : rev_sum[23:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sales_q <= '0;
            rev_q   <= '0;
            price_q <= '0;
        end else begin
            sales_q <= sales_d;
            rev_q   <= rev_d;
            price_q <= price_d;
        end
    end

    assign sales_count = sales_q;
    assign revenue     = rev_q;
`else
    // Audit counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_vend_ctrl_multi.sv
module tb_vend_ctrl_multi;
    import vend_pkg::*;

    localparam int N     = 3;
    localparam int BAL_W = 8;
    localparam int MAXB  = 200;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             coin_valid = 1'b0;
    logic [1:0]       coin_code = 2'b00;
    logic             coin_reject;
    logic             vend_req = 1'b0;
    logic [1:0]       vend_sel = 2'b00;
    logic             cancel = 1'b0;
    logic [N*BAL_W-1:0] item_prices;
    logic             restock = 1'b0;
    logic [1:0]       restock_sel = 2'b00;
    logic             vend_valid;
    logic [1:0]       vend_item;
    logic             vend_fail;
    logic [1:0]       fail_code;
    logic             coin_out_valid;
    logic [1:0]       coin_out_code;
    logic             coin_out_ready = 1'b0;
    logic [BAL_W-1:0] balance;
    logic             busy;
`ifdef VEND_AUDIT_EN
    logic [15:0]      sales_count;
    logic [23:0]      revenue;
`endif

    // item 0 = 15, item 1 = 55, item 2 = 5
    assign item_prices = {8'd5, 8'd55, 8'd15};
    int price [N] = '{15, 55, 5};

    vend_ctrl_multi #(.NUM_ITEMS(N), .BAL_W(BAL_W), .MAX_BAL(MAXB),
                      .STOCK_W(4), .INIT_STOCK(8)) dut (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_code(coin_code),
        .coin_reject(coin_reject), .vend_req(vend_req), .vend_sel(vend_sel),
        .cancel(cancel), .item_prices(item_prices), .restock(restock),
        .restock_sel(restock_sel), .vend_valid(vend_valid), .vend_item(vend_item),
        .vend_fail(vend_fail), .fail_code(fail_code), .coin_out_valid(coin_out_valid),
        .coin_out_code(coin_out_code), .coin_out_ready(coin_out_ready),
        .balance(balance), .busy(busy)
`ifdef VEND_AUDIT_EN
        , .sales_count(sales_count), .revenue(revenue)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_bal = 0;
    int exp_sales = 0;
    int exp_rev = 0;
    int coinq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cval(input int c);
        case (c)
            0: return 5;
            1: return 10;
            2: return 20;
            default: return 50;
        endcase
    endfunction

    function automatic void push_change(input int amt);
        int a = amt;
        int c;
        while (a >= 5) begin
            c = (a >= 50) ? 3 : (a >= 20) ? 2 : (a >= 10) ? 1 : 0;
            coinq.push_back(c);
            a -= cval(c);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input int code);
        coin_valid = 1'b1;
        coin_code  = 2'(code);
        tick();
        coin_valid = 1'b0;
        if (exp_bal + cval(code) <= MAXB) begin
            exp_bal += cval(code);
            chk("coin_reject", 32'(coin_reject), 32'd0);
        end else begin
            chk("coin_reject", 32'(coin_reject), 32'd1);
        end
        chk("bal_coin", 32'(balance), 32'(exp_bal));
    endtask

    // Drain change until the controller leaves VEND/CHANGE, comparing every
    // offered coin against the scoreboard head. Coin index stall_idx is held
    // off for stall_n cycles.
    task automatic serve(input int stall_idx, input int stall_n);
        int idx = 0;
        int stalled = 0;
        int guard = 0;
        logic rdy;
        while (busy === 1'b1 && guard < 200) begin
            guard++;
            rdy = 1'b0;
            if (coin_out_valid === 1'b1) begin
                chk("chg_code", 32'(coin_out_code), (coinq.size() > 0) ? 32'(coinq[0]) : 32'd4);
                if (idx == stall_idx && stalled < stall_n) stalled++;
                else rdy = 1'b1;
            end
            coin_out_ready = rdy;
            tick();
            coin_out_ready = 1'b0;
            if (rdy) begin
                if (coinq.size() > 0) begin
                    exp_bal -= cval(coinq[0]);
                    void'(coinq.pop_front());
                end
                idx++;
                if (exp_bal < 5) exp_bal = 0;
                chk("bal_chg", 32'(balance), 32'(exp_bal));
            end
        end
        chk("serve_done", 32'(busy), 32'd0);
        chk("chg_left", 32'(coinq.size()), 32'd0);
        exp_bal = 0;
        chk("bal_after_chg", 32'(balance), 32'd0);
    endtask

    task automatic do_vend(input int sel, input int fc);
        vend_req = 1'b1;
        vend_sel = 2'(sel);
        tick();
        vend_req = 1'b0;
        if (fc == 0) begin
            chk("vend_valid", 32'(vend_valid), 32'd1);
            chk("vend_item", 32'(vend_item), 32'(sel));
            chk("vend_fail", 32'(vend_fail), 32'd0);
            exp_bal -= price[sel];
            exp_sales++;
            exp_rev += price[sel];
            chk("bal_vend", 32'(balance), 32'(exp_bal));
            chk("busy_vend", 32'(busy), 32'd1);
            push_change(exp_bal);
            serve(-1, 0);
        end else begin
            chk("vend_fail", 32'(vend_fail), 32'd1);
            chk("fail_code", 32'(fail_code), 32'(fc));
            chk("vend_valid", 32'(vend_valid), 32'd0);
            chk("bal_fail", 32'(balance), 32'(exp_bal));
        end
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("busy_cancel", 32'(busy), 32'd1);
        chk("bal_cancel", 32'(balance), 32'(exp_bal));
        push_change(exp_bal);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bal"}, 32'(balance), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cov"}, 32'(coin_out_valid), 32'd0);
        chk({tag, "_coc"}, 32'(coin_out_code), 32'd0);
        chk({tag, "_vv"}, 32'(vend_valid), 32'd0);
        chk({tag, "_vi"}, 32'(vend_item), 32'd0);
        chk({tag, "_vf"}, 32'(vend_fail), 32'd0);
        chk({tag, "_fc"}, 32'(fail_code), 32'd0);
        chk({tag, "_rej"}, 32'(coin_reject), 32'd0);
`ifdef VEND_AUDIT_EN
        chk({tag, "_sales"}, 32'(sales_count), 32'd0);
        chk({tag, "_rev"}, 32'(revenue), 32'd0);
`endif
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();

        // Buy item 1 (55) with 50+20, change 15 = 10 + 5
        insert(3);
        insert(2);
        do_vend(1, 0);

        // Fill to MAX_BAL, fifth coin refused, then refund with a stalled hopper
        for (int i = 0; i < 5; i++) insert(3);
        do_cancel();
        serve(1, 3);

        // Drain item 2, out-of-stock refusal, restock in IDLE, then success
        for (int i = 0; i < 8; i++) begin
            insert(0);
            do_vend(2, 0);
        end
        insert(0);
        do_vend(2, 2);
        do_cancel();
        serve(-1, 0);
        restock     = 1'b1;
        restock_sel = 2'd2;
        tick();
        restock     = 1'b0;
        insert(0);
        do_vend(2, 0);

        // Insufficient credit and bad index
        insert(1);
        do_vend(0, 1);
        do_vend(3, 3);
        do_cancel();
        serve(-1, 0);

        // cancel + coin + vend_req together: only the refund happens
        insert(2);
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_code  = 2'd3;
        vend_req   = 1'b1;
        vend_sel   = 2'd2;
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        vend_req   = 1'b0;
        chk("tie_vv", 32'(vend_valid), 32'd0);
        chk("tie_vf", 32'(vend_fail), 32'd0);
        chk("tie_rej", 32'(coin_reject), 32'd0);
        chk("tie_busy", 32'(busy), 32'd1);
        chk("tie_bal", 32'(balance), 32'd20);
        push_change(exp_bal);
        serve(-1, 0);

`ifdef VEND_AUDIT_EN
        chk("sales", 32'(sales_count), 32'(exp_sales));
        chk("revenue", 32'(revenue), 32'(exp_rev));
`endif

        // Asynchronous reset in the middle of a stalled payout
        insert(3);
        do_cancel();
        tick();
        tick();
        chk("stall_valid", 32'(coin_out_valid), 32'd1);
        chk("stall_code", 32'(coin_out_code), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        coinq.delete();
        exp_bal = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // Stock of item 2 is back to 8: eight sales succeed, the ninth is refused
        for (int i = 0; i < 8; i++) begin
            insert(0);
            do_vend(2, 0);
        end
        insert(0);
        do_vend(2, 2);
        do_cancel();
        serve(-1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
